// File: rtl/bip_perif_timer.sv
// bip_perif_timer: memory-mapped prescaled up-counter with terminal-event interrupt.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_addr_bus   peripheral address from the CPU
//   i_cs_perif   peripheral chip select, high during a bus access
//   i_w_r        access direction, 1 = write, 0 = read
//   io_data_bus  shared bidirectional data bus, driven only on a read hit
//   o_irq        interrupt request, DONE AND IRQ_EN
//
// Register map (offset from BASE_ADDR):
//   0 CTRL     bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN
//   1 PERIOD
//   2 COUNT
//   3 STATUS   bit0 DONE, write-1-to-clear
//   4 PRESCALE
module bip_perif_timer #(
    parameter int unsigned         DATA_WIDTH = 16,
    parameter int unsigned         NB_ADDR    = 10,
    parameter logic [NB_ADDR-1:0]  BASE_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_ADDR-1:0]    i_addr_bus,
    input  logic                  i_cs_perif,
    input  logic                  i_w_r,
    inout  wire  [DATA_WIDTH-1:0] io_data_bus,
    output logic                  o_irq
);

    localparam logic [NB_ADDR-1:0] OffCtrl     = NB_ADDR'(0);
    localparam logic [NB_ADDR-1:0] OffPeriod   = NB_ADDR'(1);
    localparam logic [NB_ADDR-1:0] OffCount    = NB_ADDR'(2);
    localparam logic [NB_ADDR-1:0] OffStatus   = NB_ADDR'(3);
    localparam logic [NB_ADDR-1:0] OffPrescale = NB_ADDR'(4);

    logic                  en_q;
    logic                  autoreload_q;
    logic                  irq_en_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] period_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] prescale_q;
    logic [DATA_WIDTH-1:0] presc_q;

    logic [NB_ADDR-1:0]    offset;
    logic                  hit;
    logic                  wr_hit;
    logic                  tick;
    logic                  term;
    logic [DATA_WIDTH-1:0] rdata;

    // Offset-based range check avoids overflow of BASE_ADDR+4 near the top of the map.
    assign offset = i_addr_bus - BASE_ADDR;
    assign hit    = i_cs_perif && (i_addr_bus >= BASE_ADDR) && (offset <= OffPrescale);
    assign wr_hit = hit && i_w_r;

    assign tick = en_q && (presc_q == prescale_q);
    // Using >= rather than == makes a PERIOD written below COUNT end on the next tick.
    assign term = tick && (count_q >= period_q);

    always_comb begin
        rdata = '0;
        case (offset)
            OffCtrl:     rdata = {{(DATA_WIDTH-3){1'b0}}, irq_en_q, autoreload_q, en_q};
            OffPeriod:   rdata = period_q;
            OffCount:    rdata = count_q;
            OffStatus:   rdata = {{(DATA_WIDTH-1){1'b0}}, done_q};
            OffPrescale: rdata = prescale_q;
            default:     rdata = '0;
        endcase
    end

    assign io_data_bus = (hit && !i_w_r && !i_rst) ? rdata : 'z;
    assign o_irq       = done_q & irq_en_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            period_q     <= '0;
            count_q      <= '0;
            prescale_q   <= '0;
            presc_q      <= '0;
        end else begin
            // Prescaler idles at 0 whenever the timer is disabled.
            if (!en_q || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            // CPU writes are placed after the timer updates so they win on collision.
            if (term) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_q + 1'b1;
            end
            if (wr_hit && offset == OffCount) begin
                count_q <= io_data_bus;
            end

            if (term && !autoreload_q) begin
                en_q <= 1'b0;
            end
            if (wr_hit && offset == OffCtrl) begin
                en_q         <= io_data_bus[0];
                autoreload_q <= io_data_bus[1];
                irq_en_q     <= io_data_bus[2];
            end

            // Terminal-event set beats a coincident W1C clear.
            if (term) begin
                done_q <= 1'b1;
            end else if (wr_hit && offset == OffStatus && io_data_bus[0]) begin
                done_q <= 1'b0;
            end

            if (wr_hit && offset == OffPeriod) begin
                period_q <= io_data_bus;
            end
            if (wr_hit && offset == OffPrescale) begin
                prescale_q <= io_data_bus;
            end
        end
    end

endmodule

// File: tb/tb_bip_perif_timer.sv
module tb_bip_perif_timer;

    localparam int unsigned  DW   = 16;
    localparam int unsigned  NA   = 10;
    localparam logic [NA-1:0] BASE = 10'h100;
    localparam logic [DW-1:0] ZVAL = 16'hFFFF; // undriven bus reads as pulled-up ones

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] addr = '0;
    logic          cs = 1'b0;
    logic          w_r = 1'b0;
    logic          drv = 1'b0;
    logic [DW-1:0] dat = '0;
    wire  [DW-1:0] bus;
    wire           irq;

    assign bus = drv ? dat : 'z;
    for (genvar g = 0; g < DW; g++) begin : g_pull
        pullup (bus[g]);
    end

    always #5 clk = ~clk;

    bip_perif_timer #(
        .DATA_WIDTH (DW),
        .NB_ADDR    (NA),
        .BASE_ADDR  (BASE)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_addr_bus  (addr),
        .i_cs_perif  (cs),
        .i_w_r       (w_r),
        .io_data_bus (bus),
        .o_irq       (irq)
    );

    // Reference model state, as seen by software.
    bit          m_en, m_ar, m_ie, m_done;
    logic [DW-1:0] m_period, m_count, m_prescale, m_pre;

    typedef struct {
        bit          chk_bus;
        logic [DW-1:0] bus;
        bit          irq;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit in_range(input logic [NA-1:0] a);
        return (a >= BASE) && (a <= BASE + NA'(4));
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [NA-1:0] a);
        if (!in_range(a)) return ZVAL;
        case (a - BASE)
            NA'(0): return {13'd0, m_ie, m_ar, m_en};
            NA'(1): return m_period;
            NA'(2): return m_count;
            NA'(3): return {15'd0, m_done};
            default: return m_prescale;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit c, input bit w,
                              input logic [NA-1:0] a, input logic [DW-1:0] d);
        bit tick, term;
        if (r) begin
            {m_en, m_ar, m_ie, m_done} = '0;
            m_period = '0; m_count = '0; m_prescale = '0; m_pre = '0;
            return;
        end
        tick = m_en && (m_pre == m_prescale);
        term = tick && (m_count >= m_period);
        m_pre = (!m_en || tick) ? '0 : m_pre + 1;
        if (term) begin
            m_count = '0;
            m_done  = 1'b1;
            if (!m_ar) m_en = 1'b0;
        end else if (tick) begin
            m_count = m_count + 1;
        end
        if (c && w && in_range(a)) begin
            case (a - BASE)
                NA'(0): begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
                NA'(1): m_period = d;
                NA'(2): m_count = d;
                NA'(3): if (d[0] && !term) m_done = 1'b0;
                default: m_prescale = d;
            endcase
        end
    endtask

    // One bus cycle: drive, queue expectations, advance the model at the edge.
    task automatic cyc(input bit r, input bit c, input bit w, input logic [NA-1:0] a,
                       input logic [DW-1:0] d, input bit chk, input bit nodrv, input string tag);
        exp_t e;
        rst = r; cs = c; w_r = w; addr = a; dat = d;
        drv = c && w && !nodrv;
        if (chk) begin
            e.tag     = tag;
            e.irq     = m_done && m_ie;
            e.chk_bus = !drv;
            e.bus     = (c && !w && !r) ? model_read(a) : ZVAL;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_step(r, c, w, a, drv ? d : ZVAL);
        #1;
    endtask

    task automatic wr(input int off, input logic [DW-1:0] d, input string tag);
        cyc(1'b0, 1'b1, 1'b1, BASE + NA'(off), d, 1'b1, 1'b0, tag);
    endtask

    task automatic rd(input int off, input string tag);
        cyc(1'b0, 1'b1, 1'b0, BASE + NA'(off), '0, 1'b1, 1'b0, tag);
    endtask

    // Monitor: checks one queued expectation mid-cycle.
    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            if (me.chk_bus) begin
                n_cmp++;
                if (bus !== me.bus) begin
                    n_bad++;
                    $display("FAIL %s bus: got %h want %h (t=%0t)", me.tag, bus, me.bus, $time);
                end
            end
            n_cmp++;
            if (irq !== me.irq) begin
                n_bad++;
                $display("FAIL %s irq: got %b want %b (t=%0t)", me.tag, irq, me.irq, $time);
            end
        end
    end

    initial begin
        int op, off;
        logic [DW-1:0] d;

        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "init");
        cyc(1'b1, 1'b1, 1'b0, BASE, '0, 1'b1, 1'b0, "rst_read_z");
        for (int i = 0; i < 5; i++) rd(i, "reset_val");

        // Basic one-shot with interrupt.
        wr(1, 16'd3, "cfg"); wr(4, 16'd0, "cfg"); wr(2, 16'd0, "cfg"); wr(0, 16'h0005, "cfg");
        for (int i = 0; i < 4; i++) rd(2, "oneshot_count");
        rd(3, "oneshot_done"); rd(2, "oneshot_cnt0"); rd(0, "oneshot_en0"); rd(2, "oneshot_hold");

        // W1C on a quiet cycle.
        wr(3, 16'h0001, "w1c_quiet"); rd(3, "w1c_quiet_rd");

        // Autoreload with prescaler.
        wr(1, 16'd1, "cfg"); wr(4, 16'd2, "cfg"); wr(2, 16'd0, "cfg"); wr(0, 16'h0003, "cfg");
        for (int i = 0; i < 14; i++) rd(3, "prescale_status");
        rd(0, "autoreload_en");

        // Clear colliding with a terminal event every cycle.
        wr(1, 16'd0, "cfg"); wr(4, 16'd0, "cfg"); wr(0, 16'h0007, "cfg"); rd(2, "every_tick");
        wr(3, 16'h0001, "w1c_collide"); rd(3, "w1c_collide_rd");

        // Out-of-range and no-wait-state bus behaviour.
        wr(0, 16'h0000, "stop");
        rd(5, "rd_base5_z");
        cyc(1'b0, 1'b1, 1'b1, BASE + NA'(5), 16'h1234, 1'b1, 1'b1, "wr_base5_z");
        cyc(1'b0, 1'b1, 1'b0, BASE - NA'(1), '0, 1'b1, 1'b0, "rd_below_base_z");
        cyc(1'b0, 1'b1, 1'b1, BASE + NA'(1), '0, 1'b1, 1'b1, "wr_period_z");
        wr(1, 16'h00A5, "cfg"); rd(1, "rd_period_a5");
        cyc(1'b0, 1'b0, 1'b0, BASE + NA'(1), '0, 1'b1, 1'b0, "no_cs_z");

        // PERIOD lowered below a running COUNT.
        wr(1, 16'd100, "cfg"); wr(3, 16'h0001, "cfg"); wr(2, 16'd7, "cfg"); wr(0, 16'h0005, "cfg");
        wr(1, 16'd4, "period_below"); rd(2, "period_below_cnt"); rd(3, "period_below_done");

        // Reset mid-count.
        wr(1, 16'd50, "cfg"); wr(0, 16'h0007, "cfg"); rd(2, "pre_rst");
        cyc(1'b1, 1'b1, 1'b1, BASE + NA'(2), 16'h0033, 1'b1, 1'b0, "rst_vs_write");
        for (int i = 0; i < 5; i++) rd(i, "post_rst");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            op  = $urandom_range(0, 99);
            off = $urandom_range(0, 6);
            if (op < 2) begin
                cyc(1'b1, $urandom_range(0, 1), 1'b0, BASE + NA'(off), '0, 1'b1, 1'b0, "rnd_rst");
            end else if (op < 30) begin
                case (off)
                    0: d = 16'($urandom_range(0, 65535)) | 16'h0001;
                    1: d = 16'($urandom_range(0, 8));
                    2: d = 16'($urandom_range(0, 10));
                    4: d = 16'($urandom_range(0, 2));
                    default: d = 16'($urandom_range(0, 65535));
                endcase
                wr(off, d, "rnd_wr");
            end else if (op < 80) begin
                rd(off, "rnd_rd");
            end else begin
                cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), BASE + NA'(off), '0, 1'b1, 1'b0,
                    "rnd_idle");
            end
        end

        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "drain");
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
